// File: rtl/cdb_arbiter_if.sv
// Bundle of execute-unit result ports and the registered CDB word.
// slave is the arbiter side; master is the units/consumer side.
interface cdb_arbiter_if #(
    parameter int NUM_UNITS  = 3,
    parameter int ROBsizeLog = 6
);
    localparam int SEL_W = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]            valid_i;
    logic [NUM_UNITS*ROBsizeLog-1:0] tag_i;
    logic [NUM_UNITS*64-1:0]         val_i;
    logic [NUM_UNITS*10-1:0]         commands_i;
    logic [NUM_UNITS*4-1:0]          flags_i;
    logic                            cdbStall_i;
    logic [NUM_UNITS-1:0]            canGo_o;
    logic                            cdbValid_o;
    logic [ROBsizeLog-1:0]           cdbTag_o;
    logic [63:0]                     cdbVal_o;
    logic [9:0]                      cdbCommands_o;
    logic [3:0]                      cdbFlags_o;
    logic [SEL_W-1:0]                cdbSrc_o;

    modport slave (
        input  valid_i, tag_i, val_i, commands_i, flags_i, cdbStall_i,
        output canGo_o, cdbValid_o, cdbTag_o, cdbVal_o, cdbCommands_o,
               cdbFlags_o, cdbSrc_o
    );

    modport master (
        output valid_i, tag_i, val_i, commands_i, flags_i, cdbStall_i,
        input  canGo_o, cdbValid_o, cdbTag_o, cdbVal_o, cdbCommands_o,
               cdbFlags_o, cdbSrc_o
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one execute unit per cycle onto the common
// data bus; the winning result is registered and held while the consumer stalls.
module cdb_arbiter #(
    parameter int NUM_UNITS  = 3,
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int SEL_W      = $clog2(NUM_UNITS)
) (
    input  logic         clk_i,
    input  logic         reset_i,
    cdb_arbiter_if.slave bus
);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_UNITS - 1);
    localparam logic [SEL_W:0]   NUM_EXT  = (SEL_W + 1)'(NUM_UNITS);

    logic [ROBsizeLog-1:0] tag_arr   [NUM_UNITS];
    logic [63:0]           val_arr   [NUM_UNITS];
    logic [9:0]            cmd_arr   [NUM_UNITS];
    logic [3:0]            flags_arr [NUM_UNITS];

    logic                  cdb_valid_q, cdb_valid_d;
    logic [ROBsizeLog-1:0] cdb_tag_q,   cdb_tag_d;
    logic [63:0]           cdb_val_q,   cdb_val_d;
    logic [9:0]            cdb_cmd_q,   cdb_cmd_d;
    logic [3:0]            cdb_flags_q, cdb_flags_d;
    logic [SEL_W-1:0]      cdb_src_q,   cdb_src_d;
    logic [SEL_W-1:0]      ptr_q,       ptr_d;

    logic                  take;
    logic                  grant_any;
    logic                  grant_fire;
    logic [SEL_W-1:0]      grant_idx;
    logic [SEL_W:0]        scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unpack
            assign tag_arr[gi]   = bus.tag_i[gi*ROBsizeLog +: ROBsizeLog];
            assign val_arr[gi]   = bus.val_i[gi*64 +: 64];
            assign cmd_arr[gi]   = bus.commands_i[gi*10 +: 10];
            assign flags_arr[gi] = bus.flags_i[gi*4 +: 4];
            assign bus.canGo_o[gi] = grant_fire && (grant_idx == SEL_W'(gi));
        end
    endgenerate

    // Output register is free when empty or being drained this cycle.
    assign take = ~cdb_valid_q | ~bus.cdbStall_i;

    // Scan from ptr_q upward, wrapping, and keep the first requester found.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            scan_idx = {1'b0, ptr_q} + (SEL_W + 1)'(k);
            if (scan_idx >= NUM_EXT) begin
                scan_idx = scan_idx - NUM_EXT;
            end
            if (!grant_any && bus.valid_i[scan_idx[SEL_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[SEL_W-1:0];
            end
        end
    end

    assign grant_fire = take & grant_any & ~reset_i;

    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_val_d   = cdb_val_q;
        cdb_cmd_d   = cdb_cmd_q;
        cdb_flags_d = cdb_flags_q;
        cdb_src_d   = cdb_src_q;
        ptr_d       = ptr_q;
        if (grant_fire) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = tag_arr[grant_idx];
            cdb_val_d   = val_arr[grant_idx];
            cdb_cmd_d   = cmd_arr[grant_idx];
            cdb_flags_d = flags_arr[grant_idx];
            cdb_src_d   = grant_idx;
            ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);
        end else if (take) begin
            cdb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_val_q   <= '0;
            cdb_cmd_q   <= '0;
            cdb_flags_q <= '0;
            cdb_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_val_q   <= cdb_val_d;
            cdb_cmd_q   <= cdb_cmd_d;
            cdb_flags_q <= cdb_flags_d;
            cdb_src_q   <= cdb_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.cdbValid_o    = cdb_valid_q;
    assign bus.cdbTag_o      = cdb_tag_q;
    assign bus.cdbVal_o      = cdb_val_q;
    assign bus.cdbCommands_o = cdb_cmd_q;
    assign bus.cdbFlags_o    = cdb_flags_q;
    assign bus.cdbSrc_o      = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: idle reset, single grant, round-robin
// order and wrap, stall hold, and reset while a CDB word is pending.
module tb_cdb_arbiter;
    localparam int N  = 3;
    localparam int RL = 6;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    cdb_arbiter_if #(.NUM_UNITS(N), .ROBsizeLog(RL)) bus ();

    cdb_arbiter #(.NUM_UNITS(N), .ROBsize(32)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_sample;
        @(negedge clk_i);
    endtask

    task automatic set_unit(input int u, input logic [RL-1:0] tag, input logic [63:0] val,
                            input logic [9:0] cmd, input logic [3:0] flg);
        bus.tag_i[u*RL +: RL]     = tag;
        bus.val_i[u*64 +: 64]     = val;
        bus.commands_i[u*10 +: 10] = cmd;
        bus.flags_i[u*4 +: 4]     = flg;
    endtask

    // One line per CDB transfer accepted by the consumer.
    always @(negedge clk_i) begin
        if (bus.cdbValid_o && !bus.cdbStall_i)
            $display("cdb t=%0t src=%0d tag=%0d val=%0h", $time, bus.cdbSrc_o, bus.cdbTag_o, bus.cdbVal_o);
    end

    logic [N-1:0] exp_go;

    initial begin
        reset_i        = 1'b1;
        bus.valid_i    = '0;
        bus.tag_i      = '0;
        bus.val_i      = '0;
        bus.commands_i = '0;
        bus.flags_i    = '0;
        bus.cdbStall_i = 1'b0;
        step;
        step;
        reset_i = 1'b0;

        // Idle after reset
        repeat (10) begin
            at_sample;
            check_eq("idle_valid", 64'(bus.cdbValid_o), 64'd0);
            check_eq("idle_cango", 64'(bus.canGo_o), 64'd0);
            check_eq("idle_ptr", 64'(dut.ptr_q), 64'd0);
            step;
        end

        // Single request from unit 1
        set_unit(1, 6'd5, 64'hDEAD, 10'h011, 4'h3);
        bus.valid_i = 3'b010;
        at_sample;
        check_eq("single_cango", 64'(bus.canGo_o), 64'b010);
        step;
        bus.valid_i = '0;
        at_sample;
        check_eq("single_valid", 64'(bus.cdbValid_o), 64'd1);
        check_eq("single_tag", 64'(bus.cdbTag_o), 64'd5);
        check_eq("single_val", bus.cdbVal_o, 64'hDEAD);
        check_eq("single_src", 64'(bus.cdbSrc_o), 64'd1);
        check_eq("single_cmd", 64'(bus.cdbCommands_o), 64'h011);
        check_eq("single_flags", 64'(bus.cdbFlags_o), 64'h3);
        check_eq("single_ptr", 64'(dut.ptr_q), 64'd2);
        check_eq("single_cango_after", 64'(bus.canGo_o), 64'd0);

        reset_i = 1'b1;
        step;
        reset_i = 1'b0;

        // All three units, each dropping valid after its grant
        for (int u = 0; u < N; u++)
            set_unit(u, RL'(10 + u), 64'h100 + 64'(u), 10'(32 + u), 4'(u + 4));
        bus.valid_i = 3'b111;
        for (int c = 0; c < 4; c++) begin
            at_sample;
            exp_go = (c < 3) ? N'(1 << c) : '0;
            check_eq($sformatf("rr_cango%0d", c), 64'(bus.canGo_o), 64'(exp_go));
            if (c > 0) begin
                check_eq($sformatf("rr_valid%0d", c), 64'(bus.cdbValid_o), 64'd1);
                check_eq($sformatf("rr_src%0d", c), 64'(bus.cdbSrc_o), 64'(c - 1));
                check_eq($sformatf("rr_tag%0d", c), 64'(bus.cdbTag_o), 64'(10 + c - 1));
                check_eq($sformatf("rr_val%0d", c), bus.cdbVal_o, 64'h100 + 64'(c - 1));
            end
            step;
            if (c < 3) bus.valid_i[c] = 1'b0;
        end
        at_sample;
        check_eq("rr_drain_valid", 64'(bus.cdbValid_o), 64'd0);
        check_eq("rr_drain_ptr", 64'(dut.ptr_q), 64'd0);
        step;

        // Units 0 and 2 held continuously: alternate with pointer wrap
        bus.valid_i = 3'b101;
        for (int c = 0; c < 4; c++) begin
            at_sample;
            exp_go = (c % 2 == 0) ? 3'b001 : 3'b100;
            check_eq($sformatf("alt_cango%0d", c), 64'(bus.canGo_o), 64'(exp_go));
            check_eq($sformatf("alt_ptr%0d", c), 64'(dut.ptr_q), 64'(c % 2));
            if (c > 0)
                check_eq($sformatf("alt_src%0d", c), 64'(bus.cdbSrc_o), (c % 2 == 1) ? 64'd0 : 64'd2);
            step;
        end

        // Stall holds the unit-2 word; unit 0 waits
        bus.valid_i    = 3'b001;
        bus.cdbStall_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            at_sample;
            check_eq($sformatf("stall_cango%0d", c), 64'(bus.canGo_o), 64'd0);
            check_eq($sformatf("stall_valid%0d", c), 64'(bus.cdbValid_o), 64'd1);
            check_eq($sformatf("stall_src%0d", c), 64'(bus.cdbSrc_o), 64'd2);
            check_eq($sformatf("stall_tag%0d", c), 64'(bus.cdbTag_o), 64'd12);
            check_eq($sformatf("stall_ptr%0d", c), 64'(dut.ptr_q), 64'd0);
            step;
        end
        bus.cdbStall_i = 1'b0;
        at_sample;
        check_eq("unstall_cango", 64'(bus.canGo_o), 64'b001);
        step;

        // Reset while the unit-0 word is pending and unit 2 requests
        bus.valid_i = 3'b100;
        reset_i     = 1'b1;
        at_sample;
        check_eq("rst_pre_valid", 64'(bus.cdbValid_o), 64'd1);
        check_eq("rst_pre_src", 64'(bus.cdbSrc_o), 64'd0);
        check_eq("rst_pre_tag", 64'(bus.cdbTag_o), 64'd10);
        check_eq("rst_cango", 64'(bus.canGo_o), 64'd0);
        step;
        reset_i = 1'b0;
        at_sample;
        check_eq("rst_valid", 64'(bus.cdbValid_o), 64'd0);
        check_eq("rst_ptr", 64'(dut.ptr_q), 64'd0);
        check_eq("rst_tag", 64'(bus.cdbTag_o), 64'd0);
        check_eq("post_rst_cango", 64'(bus.canGo_o), 64'b100);
        step;
        bus.valid_i = '0;
        at_sample;
        check_eq("post_rst_valid", 64'(bus.cdbValid_o), 64'd1);
        check_eq("post_rst_src", 64'(bus.cdbSrc_o), 64'd2);
        check_eq("post_rst_tag", 64'(bus.cdbTag_o), 64'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
